// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge: 16-bit Wishbone slave driving an 8-bit async SRAM as byte accesses with wait states.
// Optional WB_SRAM_RANGE_CHECK_EN: accesses at or above MEM_WORDS return wb_err instead of touching the SRAM.
module wb_sram_bridge #(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_WORDS   = 2**23
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [1:0]        wb_sel,
    input  logic [15:0]       wb_i_dat,
    output logic [15:0]       wb_o_dat,
    output logic              wb_ack,
    output logic              wb_err,
    output logic [ADDR_W:0]   sram_addr,
    output logic [7:0]        sram_dq_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       dat_q, dat_d;
    logic              bsel_q, bsel_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic [15:0]       rdat_d;
    logic              err_d, range_err, last, stop, acc_done, active_d;

`ifdef WB_SRAM_RANGE_CHECK_EN
    assign range_err = 64'(wb_adr) >= 64'(MEM_WORDS);
`else
    logic unused_mem_words;
    assign unused_mem_words = |MEM_WORDS;
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        bsel_d   = bsel_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q | ~wb_cyc;
        rdat_d   = wb_o_dat;
        err_d    = 1'b0;
        last     = bsel_q | ~sel_q[1];
        stop     = abort_q | ~wb_cyc;
        acc_done = cnt_q == 4'(WAIT_CYCLES);
        case (state)
            IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc && wb_stb) begin
                    if (range_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        adr_d   = wb_adr;
                        we_d    = wb_we;
                        sel_d   = wb_sel;
                        dat_d   = wb_i_dat;
                        bsel_d  = ~wb_sel[0];
                        // clearing up front makes unselected read bytes return zero
                        rdat_d  = wb_we ? wb_o_dat : 16'h0000;
                        state_d = (wb_sel == 2'b00) ? RESP : SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'd0;
            end
            ACCESS: begin
                if (!acc_done) cnt_d = cnt_q + 4'd1;
                else if (we_q) state_d = HOLD;
                else begin
                    rdat_d  = bsel_q ? {sram_dq_i, wb_o_dat[7:0]} : {wb_o_dat[15:8], sram_dq_i};
                    bsel_d  = 1'b1;
                    state_d = stop ? IDLE : last ? RESP : SETUP;
                end
            end
            HOLD: begin
                bsel_d  = 1'b1;
                state_d = stop ? IDLE : last ? RESP : SETUP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        active_d = state_d inside {SETUP, ACCESS, HOLD};
    end

    // SRAM pins are decoded from the next state so every output comes straight from a flop
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= 2'b00;
            dat_q      <= 16'h0000;
            bsel_q     <= 1'b0;
            cnt_q      <= 4'd0;
            abort_q    <= 1'b0;
            wb_o_dat   <= 16'h0000;
            wb_ack     <= 1'b0;
            wb_err     <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 8'h00;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            bsel_q     <= bsel_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            wb_o_dat   <= rdat_d;
            wb_ack     <= (state_d == RESP) && !err_d;
            wb_err     <= err_d;
            sram_dq_oe <= active_d && we_d;
            sram_ce_n  <= !active_d;
            sram_oe_n  <= !(active_d && !we_d);
            sram_we_n  <= !(we_d && state_d == ACCESS);
            if (active_d) begin
                sram_addr <= {adr_d, bsel_d};
                sram_dq_o <= bsel_d ? dat_d[15:8] : dat_d[7:0];
            end
        end
    end
endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb_wb_sram_bridge: scoreboard bench for wb_sram_bridge against a behavioural byte-wide SRAM.
// Build with WB_SRAM_RANGE_CHECK_EN to exercise the out-of-range error path.
module tb_wb_sram_bridge;
    localparam int W = 1;

    typedef struct {
        logic        ack;
        logic        err;
        logic [15:0] dat;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, preload = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [23:0] adr = '0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] wdat = 16'h0000;
    logic [15:0] rdat;
    logic        ack, err;
    logic [24:0] sram_addr;
    logic [7:0]  dq_o, dq_i;
    logic        dq_oe, ce_n, oe_n, we_n;
    logic [7:0]  mem [0:1023];
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          oe_first, oe_last, we_cnt, ce_cnt;

    always #5 clk = ~clk;

    wb_sram_bridge #(.ADDR_W(24), .WAIT_CYCLES(W), .MEM_WORDS(256)) dut (
        .i_clk(clk), .i_rst(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
        .wb_sel(sel), .wb_i_dat(wdat), .wb_o_dat(rdat), .wb_ack(ack), .wb_err(err),
        .sram_addr(sram_addr), .sram_dq_o(dq_o), .sram_dq_i(dq_i), .sram_dq_oe(dq_oe),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    assign dq_i = (!ce_n && !oe_n) ? mem[sram_addr[9:0]] : 8'h00;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h77;
            mem[10'h020] <= 8'hCD;
            mem[10'h021] <= 8'hAB;
            mem[10'h200] <= 8'h34;
            mem[10'h201] <= 8'h12;
        end else if (!ce_n && !we_n && dq_oe) mem[sram_addr[9:0]] <= dq_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic w, input logic [1:0] s);
        int n = int'(s[0]) + int'(s[1]);
        return 1 + n * (W + (w ? 3 : 2));
    endfunction

    // drive one transfer, push its expectation, then compare when the bridge responds
    task automatic xfer(input string tag, input logic w, input logic [23:0] a, input logic [1:0] s,
                        input logic [15:0] d, input int drop_at,
                        input logic e_ack, input logic e_err, input logic [15:0] e_dat, input int e_lat);
        exp_t e;
        int lat = 0;
        logic ra = 1'b0, re = 1'b0;
        logic [15:0] rd = 16'h0000;
        oe_first = 0; oe_last = 0; we_cnt = 0; ce_cnt = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        sb.push_back('{e_ack, e_err, e_dat, e_lat});
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (!oe_n) begin
                if (oe_first == 0) oe_first = c;
                oe_last = c;
            end
            if (!we_n) we_cnt++;
            if (!ce_n) ce_cnt++;
            if (ack || err) begin
                lat = c; ra = ack; re = err; rd = rdat;
            end
            if (c == drop_at) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        e = sb.pop_front();
        check({tag, " ack"}, 32'(ra), 32'(e.ack));
        check({tag, " err"}, 32'(re), 32'(e.err));
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        if (e.ack && !w) check({tag, " rdata"}, 32'(rd), 32'(e.dat));
        if (lat != 0) begin
            @(negedge clk);
            check({tag, " one-cycle pulse"}, 32'({ack, err}), 32'(2'b00));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        preload = 1'b0;
        check("rst ack", 32'(ack), 32'(0));
        check("rst err", 32'(err), 32'(0));
        check("rst rdata", 32'(rdat), 32'(0));
        check("rst ctrl", 32'({ce_n, oe_n, we_n, dq_oe}), 32'(4'b1110));
        check("rst addr", 32'(sram_addr), 32'(0));
        check("rst dq_o", 32'(dq_o), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        xfer("rd16", 1'b0, 24'h000010, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'hABCD, lat_of(1'b0, 2'b11));
        check("rd16 oe first", 32'(oe_first), 32'(1));
        check("rd16 oe last", 32'(oe_last), 32'(2 * (W + 2)));

        xfer("wr hi", 1'b1, 24'h000004, 2'b10, 16'h5A3C, 0, 1'b1, 1'b0, 16'h0, lat_of(1'b1, 2'b10));
        check("wr hi we_n low", 32'(we_cnt), 32'(W + 1));
        check("wr hi byte9", 32'(mem[10'h009]), 32'(8'h5A));
        check("wr hi byte8", 32'(mem[10'h008]), 32'(8'h77));
        xfer("rb hi", 1'b0, 24'h000004, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'h5A77, lat_of(1'b0, 2'b11));

        xfer("sel00", 1'b0, 24'h000010, 2'b00, 16'h0, 0, 1'b1, 1'b0, 16'h0000, 1);
        check("sel00 ce_n", 32'(ce_cnt), 32'(0));
        xfer("rd lo", 1'b0, 24'h000010, 2'b01, 16'h0, 0, 1'b1, 1'b0, 16'h00CD, lat_of(1'b0, 2'b01));
        xfer("rd hi", 1'b0, 24'h000010, 2'b10, 16'h0, 0, 1'b1, 1'b0, 16'hAB00, lat_of(1'b0, 2'b10));

        xfer("wr16", 1'b1, 24'h000018, 2'b11, 16'hC0DE, 0, 1'b1, 1'b0, 16'h0, lat_of(1'b1, 2'b11));
        xfer("rb16", 1'b0, 24'h000018, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'hC0DE, lat_of(1'b0, 2'b11));

        xfer("abort", 1'b1, 24'h00000C, 2'b11, 16'hBEEF, 2, 1'b0, 1'b0, 16'h0, 0);
        check("abort we_n low", 32'(we_cnt), 32'(W + 1));
        check("abort lo byte", 32'(mem[10'h018]), 32'(8'hEF));
        check("abort hi byte", 32'(mem[10'h019]), 32'(8'h77));
        check("abort idle ce_n", 32'(ce_n), 32'(1));
        xfer("post abort rd", 1'b0, 24'h000010, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'hABCD, lat_of(1'b0, 2'b11));

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000030; sel = 2'b11; wdat = 16'h1357;
        repeat (2) @(negedge clk);
        check("rst mid we_n", 32'(we_n), 32'(0));
        rst_n = 1'b0;
        #1;
        check("rst mid ctrl", 32'({ce_n, oe_n, we_n, dq_oe}), 32'(4'b1110));
        check("rst mid ack", 32'(ack), 32'(0));
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst after ack", 32'(ack), 32'(0));
        xfer("post rst rd", 1'b0, 24'h000010, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'hABCD, lat_of(1'b0, 2'b11));

`ifdef WB_SRAM_RANGE_CHECK_EN
        xfer("range", 1'b0, 24'h000100, 2'b11, 16'h0, 0, 1'b0, 1'b1, 16'h0, 1);
        check("range ce_n", 32'(ce_cnt), 32'(0));
        check("range rdata held", 32'(rdat), 32'(16'hABCD));
`else
        xfer("range", 1'b0, 24'h000100, 2'b11, 16'h0, 0, 1'b1, 1'b0, 16'h1234, lat_of(1'b0, 2'b11));
        check("range ce_n", 32'(ce_cnt), 32'(2 * (W + 2)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Wishbone slave that terminates the core's external 16-bit bus (cyc/stb/we/adr/sel/dat) on an 8-bit asynchronous SRAM.
- Sits directly downstream of the upper core / bus arbiter output.
- Splits each 16-bit access into byte accesses per wb_sel, with programmable wait states, and returns a single registered ack or err.

Parameters:
- ADDR_W, 24, word address width of wb_adr; SRAM byte address is ADDR_W+1 bits.
- WAIT_CYCLES, 1, extra SRAM access cycles per byte (0..15).
- MEM_WORDS, 2**23, number of implemented 16-bit words (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-low
- wb_cyc  in  1  bus cycle
- wb_stb  in  1  strobe
- wb_we  in  1  write enable
- wb_adr  in  ADDR_W  word address
- wb_sel  in  2  byte select; [0]=dat[7:0], [1]=dat[15:8]
- wb_i_dat  in  16  write data
- wb_o_dat  out  16  read data
- wb_ack  out  1  transfer done
- wb_err  out  1  transfer error
- sram_addr  out  ADDR_W+1  byte address
- sram_dq_o  out  8  write data to pad
- sram_dq_i  in  8  read data from pad
- sram_dq_oe  out  1  pad output enable
- sram_ce_n  out  1  chip enable, low active
- sram_oe_n  out  1  output enable, low active
- sram_we_n  out  1  write enable, low active

Behaviour:
- Reset (i_rst=0, async): state IDLE; wb_ack=0, wb_err=0, wb_o_dat=0; sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0. A reset mid-transfer aborts immediately with no ack.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE:
  - On wb_cyc&wb_stb: latch adr, we, sel, dat.
  - sel==00: go to RESP directly.
  - Otherwise start with the lowest selected byte; SETUP.
- SETUP (1 cycle):
  - sram_addr={adr,byte}; ce_n=0.
  - Read: oe_n=0.
  - Write: dq_oe=1, dq_o=byte data.
  - Then ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles, counter):
  - Read: keep oe_n=0 and sample sram_dq_i into the matching wb_o_dat byte on the last ACCESS cycle.
  - Write: we_n=0.
  - Exit: read goes to next byte's SETUP, or RESP if last. Write goes to HOLD.
- HOLD (write only, 1 cycle): we_n=1, ce_n=0, data still driven; then next byte's SETUP, or RESP.
- Between bytes, ce_n/oe_n stay asserted (no bus release).
- RESP:
  - SRAM signals idle (ce_n=oe_n=we_n=1, dq_oe=0).
  - wb_ack=1 for exactly one cycle, then IDLE.
  - Unselected read bytes read as 0.
  - IDLE does not accept a new strobe in the cycle ack is high.
- Latency, W=WAIT_CYCLES, counted from the IDLE sampling edge:
  - Read: 1 + nbytes*(W+2) cycles to ack.
  - Write: 1 + nbytes*(W+3) cycles to ack.
  - Example: 16-bit read, W=1 → ack in cycle 7.
- Abort: if wb_cyc drops in SETUP/ACCESS/HOLD, finish the current byte (including HOLD for writes), skip remaining bytes, return to IDLE with no ack or err.
- wb_err is never asserted unless the optional feature is enabled.
- Address arithmetic: byte address = {adr,1'b0} for the low byte and {adr,1'b1} for the high byte; no carry across words.

Optional Feature:
- Macro: WB_SRAM_RANGE_CHECK_EN.
- Enabled: in IDLE, an access with wb_adr >= MEM_WORDS produces no SRAM activity; go to RESP with wb_err=1, wb_ack=0 for one cycle; wb_o_dat unchanged.
- Disabled: no range check, MEM_WORDS is ignored, and all addresses are passed through (external decoding handles aliasing); wb_err is constant 0.

Test Plan:
- Read, W=1, adr=0x000010, sel=11; SRAM byte 0x20=0xCD, 0x21=0xAB → wb_o_dat=0xABCD, ack in cycle 7, ack high exactly 1 cycle, oe_n low cycles 1-6.
- Write, W=0, adr=0x000004, sel=10, dat=0x5A3C → a single byte write of 0x5A to byte addr 0x09; we_n low for 1 cycle, data held through HOLD; ack in cycle 4; byte 0x08 untouched.
- Read with sel=00 → ack in cycle 1, no ce_n activity; wb_o_dat=0x0000.
- Write sel=11 with wb_cyc dropped during the first byte's ACCESS → low byte write completes including HOLD, high byte never written, no ack, FSM back in IDLE.
- i_rst asserted mid-ACCESS of a write → all SRAM controls inactive immediately, no ack; a subsequent read after reset completes normally.
- With WB_SRAM_RANGE_CHECK_EN, MEM_WORDS=0x100, adr=0x100 → err pulse in cycle 1, ack=0, ce_n stays 1. Without the macro, the same access performs a normal read.
